mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage initiator for the 1 KB byte-addressed little-endian data memory (32-bit word port,
//  combinational read, posedge write). Accepts one load/store request at a time from the
//  pipeline, drives mem_read/mem_write/mem_addr/mem_wd, and returns sign/zero-extended load data.
//  Sub-word stores (SB/SH) use read-modify-write because the memory only writes 4 bytes.
// PARAMETERS
//  MEM_BYTES  1024  memory size in bytes; any access with addr+3 > MEM_BYTES-1 is an error
// PORTS
//  clk        in   1   single clock, all state updates on posedge
//  rst        in   1   synchronous, active-high reset
//  req_valid  in   1   request present; accepted on a posedge where req_valid && req_ready
//  req_ready  out  1   high only in IDLE
//  req_write  in   1   1 = store, 0 = load
//  req_size   in   2   00 byte, 01 half, 10 word, 11 reserved (error)
//  req_signed in   1   loads only: 1 = sign-extend, 0 = zero-extend
//  req_addr   in   32  byte address, any alignment
//  req_wdata  in   32  store data, right-justified (SB uses [7:0], SH uses [15:0])
//  resp_valid out  1   one-cycle pulse: request complete; no backpressure
//  resp_rdata out  32  extended load data, valid with resp_valid; 0 for stores and errors
//  resp_err   out  1   valid with resp_valid: range error or reserved size
//  mem_read   out  1   to memory memRead
//  mem_write  out  1   to memory memWrite
//  mem_addr   out  32  to memory addr
//  mem_wd     out  32  to memory wd
//  mem_rd     in   32  from memory rd (valid same cycle as mem_read)
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; mem_read=0,
//   mem_write=0, mem_addr=0, mem_wd=0. Memory-side outputs are registered.
//  FSM: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
//   IDLE  -- accept: size 11 or range error -> RESP with err=1, no memory access;
//            load -> LOAD; store word -> STORE; store byte/half -> RMW_RD.
//   LOAD  -- mem_read=1, mem_addr=addr; at end of cycle capture mem_rd: byte -> [7:0],
//            half -> [15:0], extend per req_signed -> RESP.
//   STORE -- mem_write=1, mem_wd=req_wdata -> RESP.
//   RMW_RD-- mem_read=1; capture merged = {mem_rd[31:8], wdata[7:0]} (SB) or
//            {mem_rd[31:16], wdata[15:0]} (SH) -> RMW_WR.
//   RMW_WR-- mem_write=1, mem_wd=merged -> RESP.
//   RESP  -- resp_valid=1 for exactly one cycle -> IDLE (req_ready high next cycle).
//  Latency from accepting edge N: load/word store resp_valid in cycle N+2; SB/SH in N+3;
//   error in N+1. Throughput: one request per 3 (4 for RMW) cycles.
//  mem_read and mem_write are never high together; both low outside LOAD/STORE/RMW_*.
//  Request fields are latched at acceptance; input changes afterward are ignored.
//  Range check in full 32 bits: addr > MEM_BYTES-4 is an error (no wrap-around at 0xFFFFFFFC).
//  Unaligned addresses are legal; memory handles byte offsets natively.
//  req_valid while not IDLE: not accepted, held by requester.
//  rst mid-operation: FSM returns to IDLE, no resp_valid. rst sampled during RMW_RD -> no write
//   issued, memory unchanged. rst sampled at end of RMW_WR/STORE -> that edge's write completes.
// STRUCTURE
//  Package mau_pkg: SIZE_B/SIZE_H/SIZE_W/SIZE_RSV constants, state enum mau_state_t.
//  Sub-module mau_lane_align (combinational): load extension and store merge; FSM in top.
// TESTING
//  LW addr 8, mem[8..11]=EF BE AD DE -> mem_read one cycle, resp_rdata=0xDEADBEEF at N+2.
//  LB signed addr 8 -> 0xFFFFFFEF; LH unsigned addr 9 -> 0x0000ADBE.
//  SB 0x55 to addr 9 over 0xDEADBEEF -> read then write 0xDEAD55EF; resp_valid at N+3.
//  SW 0x12345678 addr 1021 -> resp_err=1 at N+1, mem_write never asserted; size 11 likewise.
//  rst during RMW_RD of SH addr 4 -> mem[4..7] unchanged, no resp_valid, req_ready=1 after.
//  Back-to-back: req_valid held high with 3 requests -> accepted only when ready, in order.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared constants and state encoding for the MEM-stage access unit.
package mau_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned HALF_W         = 16;
  localparam int unsigned MEM_BYTES_DFLT = 1024;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_RSV = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STORE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5
  } mau_state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response and data-memory port bundle for mem_access_unit.
interface mem_access_unit_if;
  import mau_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;

  // Access unit side
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_read, mem_write, mem_addr, mem_wd
  );

  // Pipeline + memory side
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_read, mem_write, mem_addr, mem_wd
  );

endinterface

// File: rtl/mau_lane_align.sv
// Load-data extension and sub-word store merge against the word read from memory.
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              is_signed,
  input  logic [HALF_W-1:0] wdata,
  input  logic [DATA_W-1:0] rd,
  output logic [DATA_W-1:0] load_data_c,
  output logic [DATA_W-1:0] merged_c
);

  always_comb begin
    load_data_c = rd;
    merged_c    = rd;
    case (size)
      SIZE_B: begin
        load_data_c = {{24{is_signed & rd[7]}}, rd[7:0]};
        merged_c    = {rd[31:8], wdata[7:0]};
      end
      SIZE_H: begin
        load_data_c = {{16{is_signed & rd[15]}}, rd[15:0]};
        merged_c    = {rd[31:16], wdata[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: one load/store at a time, sub-word stores via read-modify-write.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

  mau_state_t        state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [HALF_W-1:0] wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wd_q, mem_wd_d;

  logic [DATA_W-1:0] load_data_c;
  logic [DATA_W-1:0] merged_c;
  logic              bad_req_c;

  mau_lane_align u_lane_align (
    .size        (size_q),
    .is_signed   (signed_q),
    .wdata       (wdata_q),
    .rd          (bus.mem_rd),
    .load_data_c (load_data_c),
    .merged_c    (merged_c)
  );

  // Full-width compare so addresses near 0xFFFFFFFF never wrap into range
  assign bad_req_c = (bus.req_size == SIZE_RSV) || (bus.req_addr > LAST_WORD);

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    signed_d     = signed_q;
    wdata_d      = wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_addr_d   = mem_addr_q;
    mem_wd_d     = mem_wd_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          size_d       = bus.req_size;
          signed_d     = bus.req_signed;
          wdata_d      = bus.req_wdata[HALF_W-1:0];
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          if (bad_req_c) begin
            resp_err_d = 1'b1;
            state_d    = ST_RESP;
          end else begin
            mem_addr_d = bus.req_addr;
            if (!bus.req_write) begin
              state_d = ST_LOAD;
            end else if (bus.req_size == SIZE_W) begin
              mem_wd_d = bus.req_wdata;
              state_d  = ST_STORE;
            end else begin
              state_d = ST_RMW_RD;
            end
          end
        end
      end
      ST_LOAD: begin
        resp_rdata_d = load_data_c;
        state_d      = ST_RESP;
      end
      ST_STORE:  state_d = ST_RESP;
      ST_RMW_RD: begin
        mem_wd_d = merged_c;
        state_d  = ST_RMW_WR;
      end
      ST_RMW_WR: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Strobes follow the next state so they are registered yet aligned with it
    ready_d      = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
    mem_read_d   = (state_d == ST_LOAD)  || (state_d == ST_RMW_RD);
    mem_write_d  = (state_d == ST_STORE) || (state_d == ST_RMW_WR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      size_q       <= SIZE_B;
      signed_q     <= 1'b0;
      wdata_q      <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wd_q     <= '0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      wdata_q      <= wdata_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wd_q     <= mem_wd_d;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wd     = mem_wd_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 1 KB byte-array memory model.
`timescale 1ns/1ps
module tb_mem_access_unit;
  import mau_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if bus();

  mem_access_unit #(.MEM_BYTES(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [0:1023];
  int checks   = 0;
  int failures = 0;

  function automatic logic [31:0] rd_word(input logic [9:0] a);
    rd_word = {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
  endfunction

  // Combinational read port, byte-offset native
  always_comb begin
    bus.mem_rd = 32'h0;
    if (bus.mem_read && bus.mem_addr <= 32'd1020) bus.mem_rd = rd_word(bus.mem_addr[9:0]);
  end

  always @(posedge clk) begin
    if (bus.mem_write && bus.mem_addr <= 32'd1020)
      for (int i = 0; i < 4; i++) mem[bus.mem_addr[9:0] + 10'(i)] = bus.mem_wd[8*i +: 8];
  end

  task automatic set_word(input logic [9:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[a + 10'(i)] = w[8*i +: 8];
  endtask

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int n_rd, output int n_wr, output int n_both);
    lat = -1; rdata = 32'h0; err = 1'b0; n_rd = 0; n_wr = 0; n_both = 0;
    for (int w = 0; w < 8 && !bus.req_ready; w++) begin @(posedge clk); #1; end
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz;
    bus.req_signed = sg; bus.req_addr = addr; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_write = ~wr; bus.req_size = SIZE_W;
    bus.req_signed = ~sg; bus.req_addr = 32'h0000_0010; bus.req_wdata = 32'hFFFF_FFFF;
    for (int k = 1; k <= 8; k++) begin
      if (bus.mem_read) n_rd++;
      if (bus.mem_write) n_wr++;
      if (bus.mem_read && bus.mem_write) n_both++;
      if (bus.resp_valid) begin
        lat = k; rdata = bus.resp_rdata; err = bus.resp_err;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = SIZE_B;
    bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=10000",
               {bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write});
    end
    checks++;
    if ({bus.resp_rdata, bus.mem_addr, bus.mem_wd} !== 96'h0) begin
      failures++;
      $display("FAIL reset_data got rdata=%h addr=%h wd=%h exp=0", bus.resp_rdata, bus.mem_addr, bus.mem_wd);
    end
    rst = 1'b0;
  endtask

  task automatic test_load();
    logic [1:0]  sz  [8] = '{SIZE_W, SIZE_B, SIZE_B, SIZE_H, SIZE_H, SIZE_W, SIZE_B, SIZE_W};
    logic        sg  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ad  [8] = '{32'd8, 32'd8, 32'd8, 32'd9, 32'd9, 32'd9, 32'd11, 32'd1020};
    logic [31:0] exp [8] = '{32'hDEADBEEF, 32'hFFFFFFEF, 32'h000000EF, 32'h0000ADBE,
                             32'hFFFFADBE, 32'h77DEADBE, 32'hFFFFFFDE, 32'h04030201};
    int lat, n_rd, n_wr, n_both;
    logic [31:0] rdata;
    logic err;
    set_word(10'd8, 32'hDEADBEEF);
    set_word(10'd12, 32'h00000077);
    set_word(10'd1020, 32'h04030201);
    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, sz[i], sg[i], ad[i], 32'h0, lat, rdata, err, n_rd, n_wr, n_both);
      checks++;
      if (rdata !== exp[i]) begin
        failures++;
        $display("FAIL load_data[%0d] got=%h exp=%h", i, rdata, exp[i]);
      end
      checks++;
      if (lat !== 2 || err !== 1'b0 || n_rd !== 1 || n_wr !== 0) begin
        failures++;
        $display("FAIL load_timing[%0d] got lat=%0d err=%b rd=%0d wr=%0d exp lat=2 err=0 rd=1 wr=0",
                 i, lat, err, n_rd, n_wr);
      end
    end
  endtask

  task automatic test_store_word();
    int lat, n_rd, n_wr, n_both;
    logic [31:0] rdata;
    logic err;
    do_req(1'b1, SIZE_W, 1'b0, 32'd100, 32'h12345678, lat, rdata, err, n_rd, n_wr, n_both);
    checks++;
    if (lat !== 2 || err !== 1'b0 || rdata !== 32'h0 || n_rd !== 0 || n_wr !== 1) begin
      failures++;
      $display("FAIL sw_resp got lat=%0d err=%b rdata=%h rd=%0d wr=%0d exp lat=2 err=0 rdata=0 rd=0 wr=1",
               lat, err, rdata, n_rd, n_wr);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL sw_pulse got valid=%b ready=%b exp valid=0 ready=1", bus.resp_valid, bus.req_ready);
    end
    do_req(1'b0, SIZE_W, 1'b0, 32'd100, 32'h0, lat, rdata, err, n_rd, n_wr, n_both);
    checks++;
    if (rdata !== 32'h12345678) begin
      failures++;
      $display("FAIL sw_readback got=%h exp=12345678", rdata);
    end
  endtask

  task automatic test_store_sub();
    int lat, n_rd, n_wr, n_both;
    logic [31:0] rdata;
    logic err;
    do_req(1'b1, SIZE_B, 1'b0, 32'd9, 32'hAAAAAA55, lat, rdata, err, n_rd, n_wr, n_both);
    checks++;
    if (lat !== 3 || err !== 1'b0 || rdata !== 32'h0 || n_rd !== 1 || n_wr !== 1 || n_both !== 0) begin
      failures++;
      $display("FAIL sb_resp got lat=%0d err=%b rdata=%h rd=%0d wr=%0d both=%0d exp lat=3 err=0 rdata=0 rd=1 wr=1 both=0",
               lat, err, rdata, n_rd, n_wr, n_both);
    end
    do_req(1'b0, SIZE_W, 1'b0, 32'd8, 32'h0, lat, rdata, err, n_rd, n_wr, n_both);
    checks++;
    if (rdata !== 32'hDEAD55EF) begin
      failures++;
      $display("FAIL sb_readback got=%h exp=DEAD55EF", rdata);
    end
    do_req(1'b1, SIZE_H, 1'b0, 32'd101, 32'h9999ABCD, lat, rdata, err, n_rd, n_wr, n_both);
    checks++;
    if (lat !== 3 || err !== 1'b0 || n_rd !== 1 || n_wr !== 1) begin
      failures++;
      $display("FAIL sh_resp got lat=%0d err=%b rd=%0d wr=%0d exp lat=3 err=0 rd=1 wr=1", lat, err, n_rd, n_wr);
    end
    do_req(1'b0, SIZE_W, 1'b0, 32'd100, 32'h0, lat, rdata, err, n_rd, n_wr, n_both);
    checks++;
    if (rdata !== 32'h12ABCD78) begin
      failures++;
      $display("FAIL sh_readback got=%h exp=12ABCD78", rdata);
    end
  endtask

  task automatic test_errors();
    logic        wr [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0]  sz [4] = '{SIZE_W, SIZE_RSV, SIZE_W, SIZE_W};
    logic [31:0] ad [4] = '{32'd1021, 32'd0, 32'hFFFFFFFE, 32'hFFFFFFFC};
    int lat, n_rd, n_wr, n_both;
    logic [31:0] rdata;
    logic err;
    for (int i = 0; i < 4; i++) begin
      do_req(wr[i], sz[i], 1'b0, ad[i], 32'h12345678, lat, rdata, err, n_rd, n_wr, n_both);
      checks++;
      if (lat !== 1 || err !== 1'b1 || rdata !== 32'h0 || n_rd !== 0 || n_wr !== 0) begin
        failures++;
        $display("FAIL err_resp[%0d] got lat=%0d err=%b rdata=%h rd=%0d wr=%0d exp lat=1 err=1 rdata=0 rd=0 wr=0",
                 i, lat, err, rdata, n_rd, n_wr);
      end
    end
    do_req(1'b1, SIZE_W, 1'b0, 32'd1020, 32'hCAFEF00D, lat, rdata, err, n_rd, n_wr, n_both);
    checks++;
    if (lat !== 2 || err !== 1'b0 || n_wr !== 1) begin
      failures++;
      $display("FAIL sw_last_word got lat=%0d err=%b wr=%0d exp lat=2 err=0 wr=1", lat, err, n_wr);
    end
    do_req(1'b0, SIZE_W, 1'b0, 32'd1020, 32'h0, lat, rdata, err, n_rd, n_wr, n_both);
    checks++;
    if (rdata !== 32'hCAFEF00D || err !== 1'b0) begin
      failures++;
      $display("FAIL lw_last_word got=%h err=%b exp=CAFEF00D err=0", rdata, err);
    end
  endtask

  task automatic test_rst_rmw();
    int n_resp = 0;
    int n_wr = 0;
    set_word(10'd4, 32'h44332211);
    for (int w = 0; w < 8 && !bus.req_ready; w++) begin @(posedge clk); #1; end
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = SIZE_H;
    bus.req_signed = 1'b0; bus.req_addr = 32'd4; bus.req_wdata = 32'h0000BEEF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++;
    if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0) begin
      failures++;
      $display("FAIL rmw_rd_phase got rd=%b wr=%b exp rd=1 wr=0", bus.mem_read, bus.mem_write);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (bus.resp_valid) n_resp++;
      if (bus.mem_write) n_wr++;
      @(posedge clk); #1;
    end
    checks++;
    if (n_resp !== 0 || n_wr !== 0 || bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_rmw_ctrl got resp=%0d wr=%0d ready=%b exp resp=0 wr=0 ready=1",
               n_resp, n_wr, bus.req_ready);
    end
    checks++;
    if (rd_word(10'd4) !== 32'h44332211) begin
      failures++;
      $display("FAIL rst_rmw_mem got=%h exp=44332211", rd_word(10'd4));
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  sz  [3] = '{SIZE_W, SIZE_B, SIZE_H};
    logic        sg  [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] ad  [3] = '{32'd8, 32'd8, 32'd9};
    logic [31:0] exp [3] = '{32'hDEADBEEF, 32'hFFFFFFEF, 32'h0000ADBE};
    logic [31:0] got [3] = '{32'h0, 32'h0, 32'h0};
    int acc [3] = '{-10, -10, -10};
    int idx = 0;
    int nresp = 0;
    logic accepted;
    set_word(10'd8, 32'hDEADBEEF);
    for (int w = 0; w < 8 && !bus.req_ready; w++) begin @(posedge clk); #1; end
    bus.req_valid = 1'b1; bus.req_write = 1'b0;
    bus.req_size = sz[0]; bus.req_signed = sg[0]; bus.req_addr = ad[0];
    for (int c = 0; c < 40 && nresp < 3; c++) begin
      if (bus.resp_valid) begin
        if (nresp < 3) got[nresp] = bus.resp_rdata;
        nresp++;
      end
      accepted = bus.req_valid && bus.req_ready;
      @(posedge clk); #1;
      if (accepted) begin
        acc[idx] = c;
        idx++;
        if (idx < 3) begin
          bus.req_size = sz[idx]; bus.req_signed = sg[idx]; bus.req_addr = ad[idx];
        end else begin
          bus.req_valid = 1'b0;
        end
      end
    end
    bus.req_valid = 1'b0;
    checks++;
    if (nresp !== 3 || idx !== 3) begin
      failures++;
      $display("FAIL b2b_count got resp=%0d acc=%0d exp 3 3", nresp, idx);
    end
    checks++;
    if (acc[1] - acc[0] !== 3 || acc[2] - acc[1] !== 3) begin
      failures++;
      $display("FAIL b2b_spacing got %0d %0d exp 3 3", acc[1] - acc[0], acc[2] - acc[1]);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        failures++;
        $display("FAIL b2b_data[%0d] got=%h exp=%h", i, got[i], exp[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[10'(i)] = 8'h00;
    test_reset();
    test_load();
    test_store_word();
    test_store_sub();
    test_errors();
    test_rst_rmw();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
